// File: rtl/dma_sched_pkg.sv
// Shared types and engine valid-word bit positions for the DMA channel scheduler.
package dma_sched_pkg;

   typedef enum logic [1:0] {
      StArb,
      StIssue,
      StWait,
      StRelease
   } state_e;

   typedef enum logic [1:0] {
      ST_OK        = 2'd0,
      ST_PMP_FAULT = 2'd1,
      ST_TIMEOUT   = 2'd2
   } status_e;

   localparam int unsigned VALID_LOAD_BIT  = 1;
   localparam int unsigned VALID_STORE_BIT = 2;
   localparam int unsigned VALID_DONE_BIT  = 3;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: grants the first request at or after ptr_i, wrapping.
module rr_arbiter #(
   parameter int unsigned NUM_CH = 4,
   localparam int unsigned IDX_W = $clog2(NUM_CH)
) (
   input  logic [NUM_CH-1:0] req_i,
   input  logic [IDX_W-1:0]  ptr_i,
   output logic [NUM_CH-1:0] gnt_o,
   output logic [IDX_W-1:0]  idx_o
);

   // Scan from farthest to nearest so the nearest requester is the last writer.
   always_comb begin
      logic [IDX_W-1:0] ci;
      ci    = '0;
      gnt_o = '0;
      idx_o = '0;
      for (int k = int'(NUM_CH) - 1; k >= 0; k--) begin
         ci = IDX_W'((int'(ptr_i) + k) % int'(NUM_CH));
         if (req_i[ci]) begin
            gnt_o     = '0;
            gnt_o[ci] = 1'b1;
            idx_o     = ci;
         end
      end
   end

endmodule

// File: rtl/dma_chan_sched.sv
// Round-robin scheduler sharing one DMA engine between NUM_CH requesters.
// Optional wait-state watchdog is built in when DMA_SCHED_TIMEOUT_EN is defined.
module dma_chan_sched
   import dma_sched_pkg::*;
#(
   parameter int unsigned NUM_CH      = 4,
   parameter int unsigned DATA_WIDTH  = 32,
   parameter int unsigned TIMEOUT_CYC = 1024,
   localparam int unsigned IDX_W      = $clog2(NUM_CH)
) (
   input  logic                         clk_i,
   input  logic                         rst_ni,
   input  logic [NUM_CH-1:0]            req_i,
   input  logic [NUM_CH*DATA_WIDTH-1:0] len_i,
   input  logic [NUM_CH*64-1:0]         src_i,
   input  logic [NUM_CH*64-1:0]         dst_i,
   output logic [NUM_CH-1:0]            ack_o,
   output logic [1:0]                   status_o,
   output logic                         busy_o,
   output logic [IDX_W-1:0]             owner_o,
   output logic [DATA_WIDTH-1:0]        dma_start_o,
   output logic [DATA_WIDTH-1:0]        dma_length_o,
   output logic [DATA_WIDTH-1:0]        dma_src_lsb_o,
   output logic [DATA_WIDTH-1:0]        dma_src_msb_o,
   output logic [DATA_WIDTH-1:0]        dma_dst_lsb_o,
   output logic [DATA_WIDTH-1:0]        dma_dst_msb_o,
   output logic [DATA_WIDTH-1:0]        dma_done_o,
   input  logic [DATA_WIDTH-1:0]        dma_valid_i
);

   state_e                  state_q, state_d;
   logic [NUM_CH-1:0]       arb_gnt;
   logic [IDX_W-1:0]        arb_idx;
   logic                    arb_valid;
   logic [IDX_W-1:0]        ptr_q, owner_q, ptr_next;
   logic [DATA_WIDTH-1:0]   len_q;
   logic [63:0]             src_q, dst_q;
   status_e                 status_q;
   logic [NUM_CH-1:0]       ack_q;
   logic                    busy_q;
   logic                    eng_done, eng_idle, wd_expired;

   rr_arbiter #(
      .NUM_CH (NUM_CH)
   ) u_rr_arbiter (
      .req_i (req_i),
      .ptr_i (ptr_q),
      .gnt_o (arb_gnt),
      .idx_o (arb_idx)
   );

   assign arb_valid = |arb_gnt;
   assign eng_done  = dma_valid_i[VALID_DONE_BIT];
   assign eng_idle  = (dma_valid_i == '0);
   assign ptr_next  = (owner_q == IDX_W'(NUM_CH - 1)) ? '0 : owner_q + IDX_W'(1);

`ifdef DMA_SCHED_TIMEOUT_EN
   localparam int unsigned CNT_W = $clog2(TIMEOUT_CYC) + 1;
   logic [CNT_W-1:0] wd_cnt_q;

   // Cleared while issuing so the count starts at zero on the first wait cycle.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         wd_cnt_q <= '0;
      end else if (state_q == StIssue) begin
         wd_cnt_q <= '0;
      end else if (state_q == StWait && wd_cnt_q != '1) begin
         wd_cnt_q <= wd_cnt_q + CNT_W'(1);
      end
   end

   assign wd_expired = (state_q == StWait) && !eng_done &&
                       (wd_cnt_q >= CNT_W'(TIMEOUT_CYC - 1));
`else
   logic unused_timeout_cyc;
   assign unused_timeout_cyc = (TIMEOUT_CYC != 0);
   assign wd_expired         = 1'b0;
`endif

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q <= StArb;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         StArb:     if (arb_valid) state_d = StIssue;
         StIssue:   state_d = StWait;
         StWait:    if (eng_done || wd_expired) state_d = StRelease;
         StRelease: if (eng_idle) state_d = StArb;
         default:   state_d = StArb;
      endcase
   end

   always_comb begin
      dma_start_o = '0;
      dma_done_o  = '0;
      unique case (state_q)
         StIssue:   dma_start_o = DATA_WIDTH'(1);
         StRelease: dma_done_o  = DATA_WIDTH'(1);
         default:   ;
      endcase
   end

   assign dma_length_o  = len_q;
   assign dma_src_lsb_o = DATA_WIDTH'(src_q[31:0]);
   assign dma_src_msb_o = DATA_WIDTH'(src_q[63:32]);
   assign dma_dst_lsb_o = DATA_WIDTH'(dst_q[31:0]);
   assign dma_dst_msb_o = DATA_WIDTH'(dst_q[63:32]);
   assign ack_o         = ack_q;
   assign status_o      = status_q;
   assign busy_o        = busy_q;
   assign owner_o       = owner_q;

   // Holding registers decouple the requester once granted.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         len_q    <= '0;
         src_q    <= '0;
         dst_q    <= '0;
         owner_q  <= '0;
         ptr_q    <= '0;
         busy_q   <= 1'b0;
         status_q <= ST_OK;
         ack_q    <= '0;
      end else begin
         ack_q <= '0;
         unique case (state_q)
            StArb: begin
               if (arb_valid) begin
                  len_q   <= len_i[arb_idx*DATA_WIDTH +: DATA_WIDTH];
                  src_q   <= src_i[arb_idx*64 +: 64];
                  dst_q   <= dst_i[arb_idx*64 +: 64];
                  owner_q <= arb_idx;
                  busy_q  <= 1'b1;
               end
            end
            StWait: begin
               if (eng_done) begin
                  status_q <= dma_valid_i[VALID_STORE_BIT] ? ST_OK : ST_PMP_FAULT;
               end else if (wd_expired) begin
                  status_q <= ST_TIMEOUT;
               end
            end
            StRelease: begin
               if (eng_idle) begin
                  ack_q  <= NUM_CH'(1) << owner_q;
                  busy_q <= 1'b0;
                  ptr_q  <= ptr_next;
               end
            end
            default: ;
         endcase
      end
   end

endmodule
